// File: rtl/mem_hash_pkg.sv
// Shared definitions for the mem_hash drain path: scheduler state encoding
// and the minimum headroom the downstream FIFO must keep free.
// Ports: none (package only).
package mem_hash_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  // Words that can still land downstream after out_full rises.
  localparam int DRAIN_MARGIN = 3;

endpackage

// File: rtl/fifo_rr_drain_if.sv
// Bundle of the upstream per-lane FIFO read ports and the downstream FIFO
// write port. master = the drain scheduler, slave = the FIFOs around it.
// Ports: fifo_empty/eof/valid/data/r_en (upstream), out_full/w_en/data/src (downstream).
interface fifo_rr_drain_if #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int LANE_BITS = 2
);

  logic [N-1:0]         fifo_empty;
  logic [N-1:0]         fifo_eof;
  logic [N-1:0]         fifo_valid;
  logic [N*WIDTH-1:0]   fifo_data;
  logic [N-1:0]         fifo_r_en;
  logic                 out_full;
  logic                 out_w_en;
  logic [WIDTH-1:0]     out_data;
  logic [LANE_BITS-1:0] out_src;

  modport master (
    input  fifo_empty, fifo_eof, fifo_valid, fifo_data, out_full,
    output fifo_r_en, out_w_en, out_data, out_src
  );

  modport slave (
    output fifo_empty, fifo_eof, fifo_valid, fifo_data, out_full,
    input  fifo_r_en, out_w_en, out_data, out_src
  );

endinterface

// File: rtl/fifo_rr_drain_pick.sv
// Purely combinational wrap-around priority search over an N-bit mask.
// Latency: none. Backpressure: none (no state).
// Ports: mask, start (first index examined) -> found, idx (first set bit at/after start).
module rr_pick #(
  parameter int N         = 4,
  parameter int LANE_BITS = 2
) (
  input  logic [N-1:0]         mask,
  input  logic [LANE_BITS-1:0] start,
  output logic                 found,
  output logic [LANE_BITS-1:0] idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && mask[j]) begin
        found = 1'b1;
        idx   = LANE_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of N upstream FIFOs into one downstream FIFO write port.
// Latency: r_en in cycle t -> out_w_en in cycle t+2 (1-cycle FIFO read + output register).
// Backpressure: no new r_en while out_full; up to 3 words may still land afterwards.
// Ports: clk, rst_n (sync, active-low), enable, bus (master side of fifo_rr_drain_if),
//        eof_out (sticky: all lanes done and drained), err (sticky protocol error).
module fifo_rr_drain
  import mem_hash_pkg::*;
#(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int LANE_BITS = 2,
  parameter int BURST     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  fifo_rr_drain_if.master bus,
  output logic            eof_out,
  output logic            err
);

  localparam int BC_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST - 1);

  state_t               state, state_nxt;
  logic [LANE_BITS-1:0] grant, next_start, pick_idx, issue_lane, rd_lane;
  logic [BC_W-1:0]      burst_cnt;
  logic [N-1:0]         elig, exp_vld;
  logic                 pick_found, cur_ok, issue, rd_pend, rst_q, vld_bad;
  logic                 w_en_q;
  logic [WIDTH-1:0]     data_q;
  logic [LANE_BITS-1:0] src_q;

  assign elig       = ~bus.fifo_empty & ~bus.fifo_eof;
  assign next_start = (int'(grant) == N - 1) ? '0 : grant + 1'b1;

  // Scan starts just past the current lane so it is considered last.
  rr_pick #(.N(N), .LANE_BITS(LANE_BITS)) u_pick (
    .mask  (elig),
    .start (next_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cur_ok     = elig[grant] && (burst_cnt < BURST_LAST);
  assign issue      = rst_n && (state == RUN) && enable && !bus.out_full &&
                      (cur_ok || pick_found);
  assign issue_lane = cur_ok ? grant : pick_idx;

  always_comb begin
    bus.fifo_r_en = '0;
    if (issue) bus.fifo_r_en[issue_lane] = 1'b1;
  end

  // Only the lane of the outstanding read may return valid, and never more than one.
  always_comb begin
    exp_vld = '0;
    if (rd_pend) exp_vld[rd_lane] = 1'b1;
  end

  assign vld_bad = (|(bus.fifo_valid & ~exp_vld)) ||
                   ((bus.fifo_valid & (bus.fifo_valid - 1'b1)) != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (&bus.fifo_eof) state_nxt = DRAIN;
      DRAIN:   if (!rd_pend && !w_en_q) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  // Raised in the same cycle the drained pipeline is observed, held by DONE.
  assign eof_out = rst_n && (state_nxt == DONE);

  assign bus.out_w_en = w_en_q;
  assign bus.out_data = data_q;
  assign bus.out_src  = src_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      grant     <= '0;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_lane   <= '0;
      w_en_q    <= 1'b0;
      data_q    <= '0;
      src_q     <= '0;
      err       <= 1'b0;
      rst_q     <= 1'b1;
    end else begin
      rst_q   <= 1'b0;
      state   <= state_nxt;
      rd_pend <= issue;
      if (issue) begin
        grant     <= issue_lane;
        rd_lane   <= issue_lane;
        burst_cnt <= cur_ok ? burst_cnt + 1'b1 : '0;
      end
      // A read dropped upstream (lane went empty) simply produces no write.
      if (rd_pend) begin
        w_en_q <= bus.fifo_valid[rd_lane];
        data_q <= bus.fifo_data[rd_lane*WIDTH +: WIDTH];
        src_q  <= rd_lane;
      end else begin
        w_en_q <= 1'b0;
      end
      // Valid pulses from reads abandoned by a reset arrive in the first cycle out of reset.
      if (!rst_q && vld_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain.sv
module tb_fifo_rr_drain;
  import mem_hash_pkg::*;

  localparam int N = 4, W = 8, LB = 2, BURST = 4, DS_DEPTH = 8, NV = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic eof_out, err;

  always #5 clk = ~clk;

  fifo_rr_drain_if #(.N(N), .WIDTH(W), .LANE_BITS(LB)) bus ();

  fifo_rr_drain #(.N(N), .WIDTH(W), .LANE_BITS(LB), .BURST(BURST)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .bus     (bus),
    .eof_out (eof_out),
    .err     (err)
  );

  // ---------------- upstream FIFO and downstream FIFO models ----------------
  logic [W-1:0] mem [N][32];
  int           wr_cnt [N];
  int           rd_cnt [N];
  logic [W-1:0] up_dat [N];
  logic [N-1:0] up_vld, force_vld, eof_arm;
  logic         up_flush, ds_bp, ds_clr, ds_ovf;
  int           ds_cnt;

  typedef struct packed {
    logic [LB-1:0] src;
    logic [W-1:0]  dat;
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;

  for (genvar g = 0; g < N; g++) begin : g_up
    assign bus.fifo_empty[g]        = (rd_cnt[g] == wr_cnt[g]);
    assign bus.fifo_data[g*W +: W]  = up_dat[g];
  end
  assign bus.fifo_eof   = eof_arm & bus.fifo_empty;
  assign bus.fifo_valid = up_vld | force_vld;
  assign bus.out_full   = ds_bp && (ds_cnt > DS_DEPTH - DRAIN_MARGIN);

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      up_vld[i] <= 1'b0;
      if (up_flush) rd_cnt[i] <= wr_cnt[i];
      else if (bus.fifo_r_en[i] && rd_cnt[i] != wr_cnt[i]) begin
        up_vld[i] <= 1'b1;
        up_dat[i] <= mem[i][rd_cnt[i] % 32];
        rd_cnt[i] <= rd_cnt[i] + 1;
        sb_q.push_back(sb_t'{src: LB'(i), dat: mem[i][rd_cnt[i] % 32]});
      end
    end
    if (ds_clr) begin
      ds_cnt <= 0;
      ds_ovf <= 1'b0;
    end else if (bus.out_w_en) begin
      if (ds_bp && ds_cnt >= DS_DEPTH) ds_ovf <= 1'b1;
      ds_cnt <= ds_cnt + 1;
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int cyc = 0, first_ren = -1, first_wen = -1, last_ren = -1, eof_cyc = -1;
  int ren_cnt = 0, ren_full = 0, cap_n = 0;
  int cap_src [32];

  always @(negedge clk) begin
    cyc++;
    if (bus.fifo_r_en != '0) begin
      ren_cnt++;
      last_ren = cyc;
      if (first_ren < 0) first_ren = cyc;
      if (bus.out_full) ren_full++;
      chk("ren_onehot", int'($onehot(bus.fifo_r_en)), 1);
    end
    if (eof_out && eof_cyc < 0) eof_cyc = cyc;
    if (rst_n && bus.out_w_en) begin
      if (first_wen < 0) first_wen = cyc;
      if (cap_n < 32) cap_src[cap_n] = int'(bus.out_src);
      cap_n++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: unexpected write src=%0d data=%0d", bus.out_src, bus.out_data);
      end else begin
        sb_e = sb_q.pop_front();
        chk("wr_data", int'(bus.out_data), int'(sb_e.dat));
        chk("wr_src", int'(bus.out_src), int'(sb_e.src));
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int nw [N];
    int n_exp;
    int exp [8];
    int pause;
    bit eof;
  } vec_t;
  vec_t vec [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int lane, input int n);
    for (int k = 0; k < n; k++) begin
      mem[lane][wr_cnt[lane] % 32] = W'(8'h10 * lane + k);
      wr_cnt[lane]++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; up_flush = 1'b1; ds_clr = 1'b1; ds_bp = 1'b0;
    eof_arm = '0; force_vld = '0;
    step();
    step();
    sb_q.delete();
    cap_n = 0; first_ren = -1; first_wen = -1; last_ren = -1; eof_cyc = -1;
    ren_cnt = 0; ren_full = 0;
    up_flush = 1'b0; ds_clr = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int t, r0, w0;
    vec[0] = '{nw: '{2, 2, 2, 2}, n_exp: 8, exp: '{0, 0, 1, 1, 2, 2, 3, 3}, pause: 0, eof: 1'b0};
    vec[1] = '{nw: '{1, 6, 1, 0}, n_exp: 8, exp: '{0, 1, 1, 1, 1, 2, 1, 1}, pause: 0, eof: 1'b0};
    vec[2] = '{nw: '{0, 6, 2, 0}, n_exp: 8, exp: '{1, 1, 1, 1, 2, 2, 1, 1}, pause: 2, eof: 1'b0};
    vec[3] = '{nw: '{2, 1, 3, 0}, n_exp: 6, exp: '{0, 0, 1, 2, 2, 2, 0, 0}, pause: 0, eof: 1'b1};
    vec[4] = '{nw: '{0, 3, 0, 2}, n_exp: 5, exp: '{1, 1, 1, 3, 3, 0, 0, 0}, pause: 0, eof: 1'b0};

    // Reset state with data waiting and enable high.
    up_flush = 1'b1; ds_clr = 1'b1; ds_bp = 1'b0; eof_arm = '0; force_vld = '0;
    step();
    up_flush = 1'b0; ds_clr = 1'b0;
    for (int i = 0; i < N; i++) load(i, 2);
    enable = 1'b1;
    #1;
    chk("rst_ren", int'(bus.fifo_r_en), 0);
    step();
    chk("rst_w_en", int'(bus.out_w_en), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_src", int'(bus.out_src), 0);
    chk("rst_eof", int'(eof_out), 0);
    chk("rst_err", int'(err), 0);

    // Table-driven drain scenarios.
    for (int s = 0; s < NV; s++) begin
      do_reset();
      for (int i = 0; i < N; i++) load(i, vec[s].nw[i]);
      eof_arm = vec[s].eof ? '1 : '0;
      step();
      enable = 1'b1;
      if (vec[s].pause > 0) begin
        repeat (vec[s].pause) step();
        enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
          step();
          chk("pause_no_ren", int'(bus.fifo_r_en), 0);
        end
        chk("pause_pending_written", ds_cnt, vec[s].pause);
        enable = 1'b1;
        #1;
        chk("resume_lane", int'(bus.fifo_r_en), 1 << vec[s].exp[vec[s].pause]);
      end
      t = 0;
      while (ds_cnt < vec[s].n_exp && t < 100) begin
        step();
        t++;
      end
      chk("drain_timeout", int'(t >= 100), 0);
      repeat (6) step();
      chk("wr_count", ds_cnt, vec[s].n_exp);
      for (int k = 0; k < vec[s].n_exp; k++) chk("src_seq", cap_src[k], vec[s].exp[k]);
      if (s == 0) chk("first_latency", first_wen - first_ren, 2);
      if (vec[s].eof) begin
        chk("eof_delay", eof_cyc - last_ren, 3);
        chk("eof_out_set", int'(eof_out), 1);
        r0 = ren_cnt;
        eof_arm = '0;
        load(3, 1);
        repeat (5) step();
        chk("done_no_reads", ren_cnt, r0);
        chk("done_sticky", int'(eof_out), 1);
      end else begin
        chk("eof_out_low", int'(eof_out), 0);
      end
      chk("scen_err", int'(err), 0);
    end

    // Backpressure: depth 8 downstream, never read.
    do_reset();
    for (int i = 0; i < N; i++) load(i, 5);
    ds_bp = 1'b1;
    step();
    enable = 1'b1;
    repeat (60) step();
    chk("bp_writes", ds_cnt, DS_DEPTH);
    chk("bp_reads", ren_cnt, DS_DEPTH);
    chk("bp_overflow", int'(ds_ovf), 0);
    chk("bp_ren_while_full", ren_full, 0);
    chk("bp_err", int'(err), 0);

    // Spurious valid on lane 2 with nothing outstanding.
    do_reset();
    step();
    chk("fault_err_before", int'(err), 0);
    force_vld = 4'b0100;
    step();
    force_vld = '0;
    chk("fault_err_set", int'(err), 1);
    repeat (5) step();
    chk("fault_err_sticky", int'(err), 1);
    rst_n = 1'b0;
    step();
    chk("fault_err_cleared", int'(err), 0);

    // Reset in the middle of a stream.
    do_reset();
    for (int i = 0; i < N; i++) load(i, 4);
    step();
    enable = 1'b1;
    repeat (4) step();
    chk("mid_writes_seen", int'(ds_cnt > 0), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ren", int'(bus.fifo_r_en), 0);
    step();
    chk("mid_rst_w_en", int'(bus.out_w_en), 0);
    chk("mid_rst_data", int'(bus.out_data), 0);
    chk("mid_rst_src", int'(bus.out_src), 0);
    chk("mid_rst_eof", int'(eof_out), 0);
    w0 = ds_cnt;
    enable = 1'b0;
    rst_n = 1'b1;
    repeat (4) step();
    chk("mid_no_stray_write", ds_cnt, w0);
    chk("mid_err", int'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
